// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : Shared types and constants for the pipeline stall/flush sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

    typedef logic [4:0] Stall_t;

    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_WB     = 4;

    typedef logic [1:0] Ctrl_state_t;

    localparam Ctrl_state_t S_RUN   = 2'd0;
    localparam Ctrl_state_t S_MDU   = 2'd1;
    localparam Ctrl_state_t S_FLUSH = 2'd2;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam Stall_t STALL_NONE = 5'b00000;
    localparam Stall_t STALL_ALL  = 5'b11111;
    localparam Stall_t STALL_EX   = 5'b00111;
    localparam Stall_t STALL_ID   = 5'b00011;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_mdu_timer.sv
// ============================================================================
// Module  : pipeline_ctrl_mdu_timer
// Brief   : Loadable down-counter with zero flag timing MUL/DIV occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl_mdu_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear (exception abort) beats load; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module  : pipeline_ctrl
// Brief   : Stall/flush sequencer for the 5-stage pipeline: merges stall
//           requests, times MUL/DIV in EX, turns exceptions into flush+redirect.
//           Optional stall performance counter: PIPELINE_CTRL_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int          MUL_CYCLES = 2,
    parameter int          DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mdu_start,
    input  logic        mdu_div,
    input  logic        exc_valid,
    input  logic        exc_is_eret,
    input  logic [31:0] epc,
    output logic [4:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cycles
);

    localparam int            CW       = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);

    Ctrl_state_t   state_q;
    Ctrl_state_t   state_d;
    logic [31:0]   new_pc_q;
    logic [31:0]   new_pc_d;
    logic          cnt_load;
    logic          cnt_clear;
    logic [CW-1:0] cnt_load_val;
    logic [CW-1:0] cnt_value;
    logic          cnt_zero;
    Stall_t        stall_w;

    pipeline_ctrl_mdu_timer #(
        .CW (CW)
    ) u_mdu_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .count_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    assign cnt_load_val = mdu_div ? DIV_LOAD : MUL_LOAD;

    // Reset also forces the combinational hold enables low so every output
    // reads zero the moment rst rises, even with requests still asserted.
    always_comb begin
        stall_w = STALL_NONE;
        if (rst || state_q == S_FLUSH) begin
            stall_w = STALL_NONE;
        end else if (exc_valid) begin
            stall_w = STALL_ALL;
        end else if (state_q == S_RUN && mdu_start) begin
            stall_w = STALL_EX;
        end else if (state_q == S_MDU && !cnt_zero) begin
            stall_w = STALL_EX;
        end else if (stallreq_ex) begin
            stall_w = STALL_EX;
        end else if (stallreq_id) begin
            stall_w = STALL_ID;
        end
    end

    always_comb begin
        state_d   = state_q;
        new_pc_d  = new_pc_q;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            S_RUN: begin
                if (exc_valid) begin
                    state_d   = S_FLUSH;
                    new_pc_d  = exc_is_eret ? epc : EXC_VECTOR;
                    cnt_clear = 1'b1;
                end else if (mdu_start) begin
                    state_d  = S_MDU;
                    cnt_load = 1'b1;
                end
            end
            S_MDU: begin
                if (exc_valid) begin
                    state_d   = S_FLUSH;
                    new_pc_d  = exc_is_eret ? epc : EXC_VECTOR;
                    cnt_clear = 1'b1;
                end else if (cnt_zero) begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            new_pc_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign stall    = stall_w;
    assign flush    = (state_q == S_FLUSH);
    assign new_pc   = new_pc_q;
    assign mdu_busy = (state_q == S_MDU);
    assign mdu_done = (state_q == S_MDU) && cnt_zero;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= 32'h0;
        end else if (stall_w[STG_PC]) begin
            perf_q <= perf_q + 32'h1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_ctrl
// Brief   : Self-checking bench for pipeline_ctrl: directed scenarios plus
//           randomized traffic against a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    localparam int          N_MUL = 2;
    localparam int          N_DIV = 32;
    localparam logic [31:0] VEC   = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        mdu_start = 1'b0;
    logic        mdu_div = 1'b0;
    logic        exc_valid = 1'b0;
    logic        exc_is_eret = 1'b0;
    logic [31:0] epc = 32'h0;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mdu_busy;
    logic        mdu_done;
    logic [31:0] stall_cycles;
    logic [7:0]  obs;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_ctrl #(
        .MUL_CYCLES (N_MUL),
        .DIV_CYCLES (N_DIV),
        .EXC_VECTOR (VEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .mdu_start    (mdu_start),
        .mdu_div      (mdu_div),
        .exc_valid    (exc_valid),
        .exc_is_eret  (exc_is_eret),
        .epc          (epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    assign obs = {stall, flush, mdu_busy, mdu_done};

    task automatic clear_inputs();
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        mdu_start   = 1'b0;
        mdu_div     = 1'b0;
        exc_valid   = 1'b0;
        exc_is_eret = 1'b0;
        epc         = 32'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'h00 || new_pc !== 32'h0 || stall_cycles !== 32'h0)
            $display("FAIL reset: obs=%h new_pc=%h perf=%h, required 00/0/0", obs, new_pc, stall_cycles);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exception(input logic eret, input logic [31:0] epc_v, input logic [31:0] exp_pc);
        apply_reset();
        @(negedge clk);
        exc_valid = 1'b1; exc_is_eret = eret; epc = epc_v;
        #1;
        n_checks++;
        if (obs !== {5'h1F, 3'b000}) $display("FAIL exc_freeze: obs=%h, required %h", obs, {5'h1F, 3'b000});
        else n_pass++;
        @(negedge clk);
        exc_valid = 1'b0; exc_is_eret = 1'b0; epc = 32'h0;
        #1;
        n_checks++;
        if (obs !== 8'b0000_0100 || new_pc !== exp_pc)
            $display("FAIL exc_flush: obs=%h new_pc=%h, required 04/%h", obs, new_pc, exp_pc);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== 8'h00 || new_pc !== exp_pc)
            $display("FAIL exc_after: obs=%h new_pc=%h, required 00/%h", obs, new_pc, exp_pc);
        else n_pass++;
    endtask

    // Holds a DIV from the current negedge and checks all 32 occupancy cycles.
    task automatic run_div_window(input string tag);
        logic [7:0] e;
        mdu_start = 1'b1; mdu_div = 1'b1;
        for (int c = 1; c <= N_DIV; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            e = (c < N_DIV) ? {5'h07, 1'b0, (c > 1), 1'b0} : {5'h00, 1'b0, 1'b1, 1'b1};
            n_checks++;
            if (obs !== e) $display("FAIL %s cyc%0d: obs=%h, required %h", tag, c, obs, e);
            else n_pass++;
        end
        @(negedge clk);
        mdu_start = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL %s_after: obs=%h, required 00", tag, obs);
        else n_pass++;
    endtask

    task automatic test_div();
        apply_reset();
        @(negedge clk);
        run_div_window("div");
    endtask

    task automatic test_mul_with_id();
        apply_reset();
        @(negedge clk);
        mdu_start = 1'b1; mdu_div = 1'b0; stallreq_id = 1'b1;
        #1;
        n_checks++;
        if (obs !== {5'h07, 3'b000}) $display("FAIL mul_c1: obs=%h, required %h", obs, {5'h07, 3'b000});
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== {5'h03, 3'b011}) $display("FAIL mul_done: obs=%h, required %h", obs, {5'h03, 3'b011});
        else n_pass++;
        @(negedge clk);
        mdu_start = 1'b0;
        #1;
        n_checks++;
        if (obs !== {5'h03, 3'b000}) $display("FAIL mul_after: obs=%h, required %h", obs, {5'h03, 3'b000});
        else n_pass++;
        stallreq_id = 1'b0;
    endtask

    task automatic test_exc_abort();
        logic [7:0] e;
        apply_reset();
        @(negedge clk);
        mdu_start = 1'b1; mdu_div = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 10) exc_valid = 1'b1;
            #1;
            e = (c < 10) ? {5'h07, 1'b0, (c > 1), 1'b0} : {5'h1F, 3'b010};
            n_checks++;
            if (obs !== e) $display("FAIL abort cyc%0d: obs=%h, required %h", c, obs, e);
            else n_pass++;
        end
        @(negedge clk);
        exc_valid = 1'b0; mdu_start = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'b0000_0100 || new_pc !== VEC)
            $display("FAIL abort_flush: obs=%h new_pc=%h, required 04/%h", obs, new_pc, VEC);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (obs !== 8'h00) $display("FAIL abort_idle%0d: obs=%h, required 00", c, obs);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_div();
        apply_reset();
        @(negedge clk);
        mdu_start = 1'b1; mdu_div = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #1;
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'h00 || new_pc !== 32'h0 || stall_cycles !== 32'h0)
            $display("FAIL rst_mid_div: obs=%h new_pc=%h perf=%h, required 00/0/0", obs, new_pc, stall_cycles);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        run_div_window("div_restart");
    endtask

    task automatic test_perf();
        logic [31:0] e3;
        logic [31:0] e4;
`ifdef PIPELINE_CTRL_PERF_EN
        e3 = 32'd3; e4 = 32'd4;
`else
        e3 = 32'd0; e4 = 32'd0;
`endif
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            stallreq_ex = 1'b1;
        end
        @(negedge clk);
        stallreq_ex = 1'b0; mdu_start = 1'b1; mdu_div = 1'b0;
        #1;
        n_checks++;
        if (stall_cycles !== e3) $display("FAIL perf_mid: stall_cycles=%0d, required %0d", stall_cycles, e3);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        mdu_start = 1'b0;
        #1;
        n_checks++;
        if (stall_cycles !== e4) $display("FAIL perf_end: stall_cycles=%0d, required %0d", stall_cycles, e4);
        else n_pass++;
    endtask

    // Reference model tracks remaining EX occupancy and a pending flush.
    task automatic test_random();
        int          flush_pend = 0;
        int          active     = 0;
        int          rem        = 0;
        logic [31:0] pc_m       = 32'h0;
        logic [31:0] perf_m     = 32'h0;
        logic [4:0]  e_stall;
        logic [7:0]  e;
        logic [31:0] e_perf;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            stallreq_id = ($urandom_range(0, 3) == 0);
            stallreq_ex = ($urandom_range(0, 5) == 0);
            mdu_start   = ($urandom_range(0, 4) == 0);
            mdu_div     = ($urandom_range(0, 3) == 0);
            exc_valid   = ($urandom_range(0, 19) == 0);
            exc_is_eret = $urandom_range(0, 1) == 1;
            epc         = $urandom;
            #1;
            if (flush_pend != 0) begin
                e_stall = 5'h00;
                e = {e_stall, 3'b100};
            end else begin
                if (exc_valid) e_stall = 5'h1F;
                else if ((active == 0 && mdu_start) || (active != 0 && rem > 1)) e_stall = 5'h07;
                else if (stallreq_ex) e_stall = 5'h07;
                else if (stallreq_id) e_stall = 5'h03;
                else e_stall = 5'h00;
                e = {e_stall, 1'b0, (active != 0), (active != 0 && rem == 1)};
            end
`ifdef PIPELINE_CTRL_PERF_EN
            e_perf = perf_m;
`else
            e_perf = 32'h0;
`endif
            n_checks++;
            if (obs !== e || new_pc !== pc_m || stall_cycles !== e_perf)
                $display("FAIL rand%0d: obs=%h pc=%h perf=%0d, required %h/%h/%0d",
                         i, obs, new_pc, stall_cycles, e, pc_m, e_perf);
            else n_pass++;
            perf_m = perf_m + {31'h0, e_stall[0]};
            if (flush_pend != 0) begin
                flush_pend = 0;
            end else if (exc_valid) begin
                flush_pend = 1;
                pc_m       = exc_is_eret ? epc : VEC;
                active     = 0;
                rem        = 0;
            end else if (active != 0) begin
                rem = rem - 1;
                if (rem == 0) active = 0;
            end else if (mdu_start) begin
                active = 1;
                rem    = (mdu_div ? N_DIV : N_MUL) - 1;
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_exception(1'b0, 32'h0000_0000, VEC);
        test_exception(1'b1, 32'h8000_1234, 32'h8000_1234);
        test_div();
        test_mul_with_id();
        test_exc_abort();
        test_reset_mid_div();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
